// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x WIDTH register file with two combinational reads and one synchronous write.
// Latency: writes and reset take effect on the rising CLK edge; reads are zero-cycle (optional write bypass).
// Backpressure: none. A write is accepted on every edge where WRITE=1; reset wins over write.
module reg_file #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [WIDTH-1:0]  IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [WIDTH-1:0]  OUT1,
    output logic [WIDTH-1:0]  OUT2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (WRITE) begin
            regs[INADDRESS] <= IN;
        end
    end

    // Bypass only forwards a write that will actually land on this edge.
    logic wr_live;
    logic byp1;
    logic byp2;

    assign wr_live = (BYPASS != 0) && WRITE && !RESET;
    assign byp1    = wr_live && (OUT1ADDRESS == INADDRESS);
    assign byp2    = wr_live && (OUT2ADDRESS == INADDRESS);

    always_comb begin
        OUT1 = regs[OUT1ADDRESS];
        OUT2 = regs[OUT2ADDRESS];
        if (byp1) OUT1 = IN;
        if (byp2) OUT2 = IN;
    end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: two instances (no bypass / bypass) share stimulus; a scoreboard queue holds
// expected read values computed from a plain array model of the register contents.
module tb_reg_file;

    logic       CLK;
    logic       RESET;
    logic [7:0] IN;
    logic [2:0] INADDRESS;
    logic       WRITE;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] o1_nb, o2_nb, o1_b, o2_b;

    reg_file #(.WIDTH(8), .ADDR_W(3), .BYPASS(0)) dut_nb (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(o1_nb), .OUT2(o2_nb)
    );

    reg_file #(.WIDTH(8), .ADDR_W(3), .BYPASS(1)) dut_b (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(o1_b), .OUT2(o2_b)
    );

    initial CLK = 1'b0;
    always #50 CLK = ~CLK;

    typedef struct {
        string      name;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] b1;
        logic [7:0] b2;
    } exp_t;

    exp_t       sbq[$];
    int         pend;
    int         checks;
    int         failures;
    logic [7:0] model [8];

    // Register contents as the programmer sees them: reset clears all, else a write replaces one entry.
    task automatic tick();
        @(posedge CLK);
        if (RESET) begin
            for (int i = 0; i < 8; i++) model[i] = 8'h00;
        end else if (WRITE) begin
            model[INADDRESS] = IN;
        end
        @(negedge CLK);
    endtask

    function automatic logic [7:0] rd_byp(input logic [2:0] a);
        if (WRITE && !RESET && a == INADDRESS) return IN;
        return model[a];
    endfunction

    task automatic check(input string name);
        exp_t e;
        #1;
        e.name = name;
        e.e1   = model[OUT1ADDRESS];
        e.e2   = model[OUT2ADDRESS];
        e.b1   = rd_byp(OUT1ADDRESS);
        e.b2   = rd_byp(OUT2ADDRESS);
        sbq.push_back(e);
        pend++;
        #1;
    endtask

    task automatic cmp(input string name, input string port, input logic [7:0] act,
                       input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s %s actual=%h required=%h (t=%0t)", name, port, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            wait (pend != 0);
            e = sbq.pop_front();
            pend--;
            cmp(e.name, "nb.OUT1", o1_nb, e.e1);
            cmp(e.name, "nb.OUT2", o2_nb, e.e2);
            cmp(e.name, "b.OUT1",  o1_b,  e.b1);
            cmp(e.name, "b.OUT2",  o2_b,  e.b2);
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        WRITE = 1'b1; INADDRESS = a; IN = d;
        tick();
        WRITE = 1'b0;
    endtask

    initial begin : stim
        pend = 0; checks = 0; failures = 0;
        for (int i = 0; i < 8; i++) model[i] = 8'hxx;
        RESET = 1'b1; WRITE = 1'b0; IN = 8'h00; INADDRESS = 3'd0;
        OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
        @(negedge CLK);
        tick();
        RESET = 1'b0;

        // reset sweep
        for (int a = 0; a < 8; a++) begin
            OUT1ADDRESS = 3'(a); OUT2ADDRESS = 3'(7 - a);
            check("reset_sweep");
        end

        // basic write/read, observed before and after the edge
        IN = 8'd95; INADDRESS = 3'd4; WRITE = 1'b1;
        OUT1ADDRESS = 3'd4; OUT2ADDRESS = 3'd4;
        check("wr95_pre");
        tick();
        WRITE = 1'b0;
        check("wr95_post");

        // disabled write leaves R2 untouched
        IN = 8'hFF; INADDRESS = 3'd2; WRITE = 1'b0;
        tick();
        OUT1ADDRESS = 3'd2;
        check("nowrite_r2");
        wr(3'd1, 8'd6);
        wr(3'd2, 8'd9);
        OUT1ADDRESS = 3'd1; OUT2ADDRESS = 3'd2;
        check("r1_r2");

        // reset and write on the same edge
        RESET = 1'b1; WRITE = 1'b1; IN = 8'hAA; INADDRESS = 3'd3;
        OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd4;
        check("rst_wr_pre");
        tick();
        RESET = 1'b0; WRITE = 1'b0;
        for (int a = 0; a < 8; a++) begin
            OUT1ADDRESS = 3'(a); OUT2ADDRESS = 3'd3;
            check("rst_wr_post");
        end

        // back-to-back writes to R5, bypass visible before the second edge
        OUT1ADDRESS = 3'd5; OUT2ADDRESS = 3'd0;
        wr(3'd5, 8'h0F);
        IN = 8'hF0; INADDRESS = 3'd5; WRITE = 1'b1;
        check("b2b_pre");
        tick();
        WRITE = 1'b0;
        check("b2b_post");

        // read address changes with no clock edge
        OUT1ADDRESS = 3'd4; check("addr_tog_a");
        OUT1ADDRESS = 3'd5; check("addr_tog_b");
        OUT1ADDRESS = 3'd1; check("addr_tog_c");

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            RESET       = ($urandom_range(0, 19) == 0);
            WRITE       = ($urandom_range(0, 3) != 0);
            IN          = 8'($urandom);
            INADDRESS   = 3'($urandom);
            OUT1ADDRESS = ($urandom_range(0, 2) == 0) ? INADDRESS : 3'($urandom);
            OUT2ADDRESS = ($urandom_range(0, 2) == 0) ? INADDRESS : 3'($urandom);
            check("rand_pre");
            OUT1ADDRESS = 3'($urandom);
            check("rand_pre_mv");
            tick();
            RESET = 1'b0; WRITE = 1'b0;
            check("rand_post");
        end

        for (int k = 0; k < 100 && pend != 0; k++) #1;
        checks++;
        if (pend != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", pend);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
